// File: rtl/puf_eval_sequencer_if.sv
// Host and oscillator-bank signals of the PUF evaluation sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface puf_eval_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [7:0]       chall_in;
  logic             abort;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             ro_en;
  logic             cnt_rst;
  logic [2:0]       sel_a;
  logic [2:0]       sel_b;
  logic             busy;
  logic             resp_valid;
  logic             resp_ack;
  logic [7:0]       response;
  logic             tie;

  modport master (
    output start, chall_in, abort, cnt_a, cnt_b, resp_ack,
    input  ro_en, cnt_rst, sel_a, sel_b, busy, resp_valid, response, tie
  );

  modport slave (
    input  start, chall_in, abort, cnt_a, cnt_b, resp_ack,
    output ro_en, cnt_rst, sel_a, sel_b, busy, resp_valid, response, tie
  );
endinterface

// File: rtl/puf_eval_sequencer.sv
// Runs one 8-bit ring-oscillator PUF challenge/response evaluation:
// per bit, clear counters, gate oscillators for WINDOW cycles, settle, compare.
module puf_eval_sequencer #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  puf_eval_sequencer_if.slave bus
);

  localparam int unsigned TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] ch_reg;
  logic [2:0] bit_idx;
  logic [TW-1:0] timer;
  logic [7:0] sh;
  logic       tie_acc;
  logic       ro_en;
  logic       cnt_rst;
  logic       busy;
  logic       resp_valid;
  logic [7:0] response;
  logic       tie;

  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             gt;
  logic             eq;

  assign cnt_a = bus.cnt_a;
  assign cnt_b = bus.cnt_b;
  assign gt    = (cnt_a > cnt_b);
  assign eq    = (cnt_a == cnt_b);

  // Selects are slices of the challenge register, so they only move with it.
  assign bus.sel_a      = ch_reg[2:0];
  assign bus.sel_b      = ch_reg[7:5];
  assign bus.ro_en      = ro_en;
  assign bus.cnt_rst    = cnt_rst;
  assign bus.busy       = busy;
  assign bus.resp_valid = resp_valid;
  assign bus.response   = response;
  assign bus.tie        = tie;

  // Outputs are set on the transition into each state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ch_reg     <= 8'h00;
      bit_idx    <= 3'd0;
      timer      <= '0;
      sh         <= 8'h00;
      tie_acc    <= 1'b0;
      ro_en      <= 1'b0;
      cnt_rst    <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= 8'h00;
      tie        <= 1'b0;
    end else if (bus.abort) begin
      state      <= S_IDLE;
      ro_en      <= 1'b0;
      cnt_rst    <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ch_reg  <= bus.chall_in;
            bit_idx <= 3'd0;
            sh      <= 8'h00;
            tie_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          timer   <= '0;
          ro_en   <= 1'b1;
          cnt_rst <= 1'b0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (timer == TW'(WINDOW - 1)) begin
            timer <= '0;
            ro_en <= 1'b0;
            state <= S_SETTLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SETTLE: begin
          if (timer == TW'(SETTLE - 1)) begin
            timer <= '0;
            state <= S_COMPARE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_COMPARE: begin
          sh[bit_idx] <= gt;
          if (eq) tie_acc <= 1'b1;
          cnt_rst <= 1'b1;
          if (bit_idx == 3'd7) begin
            response   <= {gt, sh[6:0]};
            tie        <= tie_acc | eq;
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            ch_reg  <= {ch_reg[6:0], ch_reg[7]};
            state   <= S_CLEAR;
          end
        end
        S_DONE: begin
          if (bus.resp_ack) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          ro_en      <= 1'b0;
          cnt_rst    <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer with WINDOW=4, SETTLE=2 (8 cycles per bit).
module tb_puf_eval_sequencer;

  localparam int unsigned WINDOW  = 4;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BIT_CYC = WINDOW + SETTLE + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  puf_eval_sequencer_if #(.CNT_W(CNT_W)) bus ();

  puf_eval_sequencer #(
    .WINDOW(WINDOW),
    .SETTLE(SETTLE),
    .CNT_W (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  // Unsigned-sensitive patterns: a signed compare would order these the other way.
  task automatic drive_counts(input logic gt, input logic eq);
    if (eq) begin
      bus.cnt_a = 16'h1234; bus.cnt_b = 16'h1234;
    end else if (gt) begin
      bus.cnt_a = 16'h8000; bus.cnt_b = 16'h7FFF;
    end else begin
      bus.cnt_a = 16'h0001; bus.cnt_b = 16'hFFFF;
    end
  endtask

  task automatic run_eval(input logic [7:0] ch, input logic [7:0] gt_mask,
                          input logic [7:0] eq_mask, input logic [7:0] exp_resp,
                          input logic exp_tie, input logic [7:0] prev_resp,
                          input logic prev_tie, input int start_at, input int abort_at);
    logic aborted;
    aborted      = 1'b0;
    bus.chall_in = ch;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.chall_in = 8'h00;
    for (int c = 0; c < int'(8 * BIT_CYC); c++) begin
      int k;
      int p;
      logic [7:0] r;
      k = c / int'(BIT_CYC);
      p = c % int'(BIT_CYC);
      r = rotl(ch, k);
      drive_counts(gt_mask[k], eq_mask[k]);
      check("sel_a", 32'(bus.sel_a), 32'(r[2:0]));
      check("sel_b", 32'(bus.sel_b), 32'(r[7:5]));
      check("ro_en", 32'(bus.ro_en), 32'(p >= 1 && p <= int'(WINDOW)));
      check("cnt_rst", 32'(bus.cnt_rst), 32'(p == 0));
      check("busy", 32'(bus.busy), 32'd1);
      check("resp_valid_early", 32'(bus.resp_valid), 32'd0);
      check("response_held", 32'(bus.response), 32'(prev_resp));
      check("tie_held", 32'(bus.tie), 32'(prev_tie));
      if (c == start_at) begin
        bus.start = 1'b1; bus.chall_in = ~ch;
      end else begin
        bus.start = 1'b0; bus.chall_in = 8'h00;
      end
      if (c == abort_at) bus.abort = 1'b1;
      step();
      if (c == abort_at) begin
        bus.abort = 1'b0;
        aborted   = 1'b1;
        check("abort_ro_en", 32'(bus.ro_en), 32'd0);
        check("abort_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_response", 32'(bus.response), 32'(prev_resp));
        check("abort_tie", 32'(bus.tie), 32'(prev_tie));
        step();
        check("abort_stays_idle", 32'(bus.busy), 32'd0);
        break;
      end
    end
    bus.start = 1'b0;
    if (!aborted) begin
      check("resp_valid_at_64", 32'(bus.resp_valid), 32'd1);
      check("response", 32'(bus.response), 32'(exp_resp));
      check("tie", 32'(bus.tie), 32'(exp_tie));
      check("done_ro_en", 32'(bus.ro_en), 32'd0);
      check("done_cnt_rst", 32'(bus.cnt_rst), 32'd1);
    end
  endtask

  // Response held until ack; a start that coincides with ack is not taken.
  task automatic ack_resp(input logic [7:0] exp_resp, input logic exp_tie);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_response", 32'(bus.response), 32'(exp_resp));
      check("hold_tie", 32'(bus.tie), 32'(exp_tie));
    end
    bus.resp_ack = 1'b1;
    bus.start    = 1'b1;
    bus.chall_in = 8'hFF;
    step();
    bus.resp_ack = 1'b0;
    bus.start    = 1'b0;
    bus.chall_in = 8'h00;
    check("ack_valid_low", 32'(bus.resp_valid), 32'd0);
    check("ack_busy_low", 32'(bus.busy), 32'd0);
    check("ack_response_kept", 32'(bus.response), 32'(exp_resp));
    step();
    check("ack_start_ignored", 32'(bus.busy), 32'd0);
    check("idle_cnt_rst", 32'(bus.cnt_rst), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.chall_in = 8'h00;
    bus.abort    = 1'b0;
    bus.resp_ack = 1'b0;
    bus.cnt_a    = '0;
    bus.cnt_b    = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_ro_en", 32'(bus.ro_en), 32'd0);
    check("rst_cnt_rst", 32'(bus.cnt_rst), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_response", 32'(bus.response), 32'h00);
    check("rst_tie", 32'(bus.tie), 32'd0);
    check("rst_sel_a", 32'(bus.sel_a), 32'd0);
    check("rst_sel_b", 32'(bus.sel_b), 32'd0);
    #9 rst = 1'b1;
    step();

    // Even bits a>b, odd bits a<b.
    run_eval(8'hA5, 8'h55, 8'h00, 8'h55, 1'b0, 8'h00, 1'b0, -1, -1);
    ack_resp(8'h55, 1'b0);

    // Tie on bit 3, a>b elsewhere.
    run_eval(8'h3C, 8'hFF, 8'h08, 8'hF7, 1'b1, 8'h55, 1'b0, -1, -1);
    ack_resp(8'hF7, 1'b1);

    // Start pulsed during RUN of bit 2 is ignored.
    run_eval(8'h0F, 8'h0F, 8'h00, 8'h0F, 1'b0, 8'hF7, 1'b1, 2 * BIT_CYC + 2, -1);
    ack_resp(8'h0F, 1'b0);

    // Abort during SETTLE of bit 5, then a full evaluation.
    run_eval(8'h81, 8'hFF, 8'h00, 8'hFF, 1'b0, 8'h0F, 1'b0, -1, 5 * BIT_CYC + 5);
    run_eval(8'hC3, 8'hAA, 8'h00, 8'hAA, 1'b0, 8'h0F, 1'b0, -1, -1);
    ack_resp(8'hAA, 1'b0);

    // Asynchronous reset mid-RUN, between clock edges.
    bus.chall_in = 8'h5A;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    step();
    step();
    check("pre_rst_ro_en", 32'(bus.ro_en), 32'd1);
    check("pre_rst_response", 32'(bus.response), 32'hAA);
    #3 rst = 1'b0;
    #1;
    check("arst_ro_en", 32'(bus.ro_en), 32'd0);
    check("arst_cnt_rst", 32'(bus.cnt_rst), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_response", 32'(bus.response), 32'h00);
    check("arst_tie", 32'(bus.tie), 32'd0);
    check("arst_sel_a", 32'(bus.sel_a), 32'd0);
    check("arst_sel_b", 32'(bus.sel_b), 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_eval_sequencer.md
Name: puf_eval_sequencer

Overview:
Controller that runs one complete 8-bit challenge/response evaluation on the ring-oscillator PUF datapath. It latches a challenge and derives the two ring-oscillator select codes for each bit. For each bit it gates the oscillators for a fixed measurement window, clears and freezes the edge counters, compares the two counts, and assembles the 8-bit response. The block sits between the host interface and the oscillator bank, muxes and counters, replacing ad-hoc reset chaining with an explicit FSM and a valid/ack handshake.

Parameters:
WINDOW, 256, measurement window length in clk cycles with oscillators enabled (legal range >=1)
SETTLE, 2, cycles waited after oscillators are disabled before counts are compared; covers counter synchronisers (legal range >=1)
CNT_W, 16, width of each oscillator edge-count input

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request a new evaluation; sampled only in IDLE
chall_in  input  8  challenge; latched on the cycle start is accepted
abort  input  1  synchronous abort; returns the FSM to IDLE from any state
cnt_a  input  CNT_W  edge count of the oscillator selected by sel_a
cnt_b  input  CNT_W  edge count of the oscillator selected by sel_b
ro_en  output  1  oscillator enable
cnt_rst  output  1  synchronous clear for both edge counters
sel_a  output  3  select for lower oscillator group mux
sel_b  output  3  select for upper oscillator group mux
busy  output  1  high in every state except IDLE
resp_valid  output  1  response available; held until acknowledged
resp_ack  input  1  host acknowledge of response
response  output  8  last completed response; stable while resp_valid=1
tie  output  1  at least one bit of the last response had cnt_a==cnt_b

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ro_en=0, cnt_rst=1, busy=0, resp_valid=0, response=8'h00, tie=0, sel_a=sel_b=0; internal challenge register, bit index, timer, shift register and tie accumulator cleared.
- Internal state: ch_reg[7:0]; bit_idx[2:0]; timer wide enough for max(WINDOW,SETTLE)-1; shift register sh[7:0]; tie accumulator.
- sel_a=ch_reg[2:0] and sel_b=ch_reg[7:5] at all times. Both are registered and change only when ch_reg changes.
- States and outputs:
  - IDLE: ro_en=0, cnt_rst=1. If start=1: ch_reg<=chall_in, bit_idx<=0, sh<=0, tie accumulator<=0, next state CLEAR.
  - CLEAR: lasts 1 cycle; ro_en=0, cnt_rst=1. Then timer<=0 and next state RUN.
  - RUN: ro_en=1, cnt_rst=0; timer increments. When timer==WINDOW-1: next state SETTLE, timer<=0. ro_en is therefore high for exactly WINDOW cycles.
  - SETTLE: ro_en=0, cnt_rst=0; after SETTLE cycles, next state COMPARE.
  - COMPARE: lasts 1 cycle.
    - sh[bit_idx]<=(cnt_a>cnt_b), compared unsigned.
    - If cnt_a==cnt_b, the bit is 0 and the tie accumulator is set.
    - If bit_idx==7: response<=final sh value (including this bit), tie<=accumulator, next state DONE.
    - Otherwise: bit_idx++, ch_reg<=rotate-left-1(ch_reg), next state CLEAR.
  - DONE: resp_valid=1, ro_en=0, cnt_rst=1. On resp_ack=1: resp_valid deasserts the next cycle and next state is IDLE. resp_ack is ignored in all other states.
- Latency: cycles per bit = WINDOW+SETTLE+2. resp_valid first rises 8*(WINDOW+SETTLE+2) cycles after the edge that samples start.
- start while busy=1 is ignored and not queued. start and resp_ack together in DONE: only the ack acts; a new start is accepted from IDLE on the following cycle.
- response and tie hold their previous values throughout a new evaluation. They update only on COMPARE of bit 7.
- abort=1 (highest priority after reset), from any state, on the next edge:
  - state<=IDLE, ro_en=0, cnt_rst=1, resp_valid=0.
  - response and tie keep their previous values; the partial sh is discarded.
- Asynchronous reset mid-evaluation behaves as abort, except that response and tie are also cleared.
- Count inputs are sampled only in COMPARE; values in other states are don't-care.

Test Plan:
(All runs use WINDOW=4, SETTLE=2, so each bit takes 8 cycles.)
1. Reset, then start=1 for 1 cycle with chall_in=8'hA5.
   -> sel_a/sel_b for bits 0..7 follow rotations of A5: sel_a=5, sel_b=5 for bit 0; sel_a=3, sel_b=2 for bit 1; and so on.
   -> ro_en high for exactly 4 cycles per bit.
   -> resp_valid rises exactly 64 cycles after the start edge.
2. Bench counters driven so that cnt_a>cnt_b on even bits and cnt_a<cnt_b on odd bits.
   -> response=8'h55, tie=0; values held until resp_ack; busy=0 the cycle after ack.
3. cnt_a==cnt_b on bit 3, cnt_a>cnt_b on all other bits.
   -> response=8'hF7, tie=1.
4. start pulsed again during RUN of bit 2.
   -> ignored; completion timing unchanged at 64 cycles.
   -> previous response stays visible on response until the new bit 7 COMPARE.
5. abort asserted during SETTLE of bit 5.
   -> next cycle: IDLE, ro_en=0, cnt_rst=1, resp_valid=0, response unchanged.
   -> a subsequent start runs a full 64-cycle evaluation.
6. rst driven low asynchronously mid-RUN, between clock edges.
   -> ro_en=0, cnt_rst=1, busy=0, response=8'h00 immediately, without waiting for a clock edge.
